// File: rtl/soc_system_led_pwm.sv
// soc_system_led_pwm: global PWM brightness and optional per-LED blink between the LED PIO and the LEDR pins.
// Define SOC_LED_PWM_BLINK_EN to build the BLINK_MASK, BLINK_PERIOD and STATUS registers.
module soc_system_led_pwm #(
    parameter int NUM_LEDS = 10,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] led_in,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [NUM_LEDS-1:0] led_out
);
    localparam logic [PWM_BITS-1:0] PWM_MAX = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic                wr;
    logic                wrap;
    logic                pwm_on;
    logic                unused;
    logic [PWM_BITS-1:0] duty, duty_active, pwm_cnt;
    logic [NUM_LEDS-1:0] led_q, blink_mask;
    logic                blink_phase;

    assign wr = chipselect && !write_n;
    assign wrap = pwm_cnt == PWM_MAX;
    assign pwm_on = pwm_cnt < duty_active;
    assign unused = ^writedata;

    // duty_active only reloads on wrap so a frame is never cut short
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            duty <= '1;
            duty_active <= '1;
            pwm_cnt <= '0;
            led_q <= '0;
            led_out <= '0;
        end else begin
            if (wr && address == 2'd0) duty <= writedata[PWM_BITS-1:0];
            if (wrap) duty_active <= duty;
            pwm_cnt <= wrap ? '0 : pwm_cnt + 1'b1;
            led_q <= led_in;
            led_out <= led_q & {NUM_LEDS{pwm_on}} & (~blink_mask | {NUM_LEDS{blink_phase}});
        end

`ifdef SOC_LED_PWM_BLINK_EN
    logic [15:0] blink_period, frame_cnt;

    // a period write restarts the blink cycle, overriding a coincident wrap
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            blink_mask <= '0;
            blink_period <= '0;
            frame_cnt <= '0;
            blink_phase <= 1'b1;
        end else begin
            if (wr && address == 2'd1) blink_mask <= writedata[NUM_LEDS-1:0];
            if (wr && address == 2'd2) begin
                blink_period <= writedata[15:0];
                frame_cnt <= '0;
                blink_phase <= 1'b1;
            end else if (blink_period == 16'd0) begin
                frame_cnt <= '0;
                blink_phase <= 1'b1;
            end else if (wrap) begin
                frame_cnt <= frame_cnt == blink_period - 16'd1 ? 16'd0 : frame_cnt + 16'd1;
                if (frame_cnt == blink_period - 16'd1) blink_phase <= ~blink_phase;
            end
        end

    always_comb
        readdata = address == 2'd0 ? 32'(duty) :
                   address == 2'd1 ? 32'(blink_mask) :
                   address == 2'd2 ? {16'd0, blink_period} :
                                     {frame_cnt, 15'd0, blink_phase};
`else
    assign blink_mask = '0;
    assign blink_phase = 1'b1;

    always_comb
        readdata = address == 2'd0 ? 32'(duty) : 32'd0;
`endif

endmodule

// File: tb/tb_soc_system_led_pwm.sv
// tb_soc_system_led_pwm: directed checks of reset, PWM duty, wrap-coincident duty writes and blink behaviour.
module tb_soc_system_led_pwm;
    logic        clk;
    logic        reset;
    logic [9:0]  led_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  led_out;
    int          total;
    int          bad;
    int          on;

`ifdef SOC_LED_PWM_BLINK_EN
    localparam logic [31:0] STATUS_RST = 32'h1;
`else
    localparam logic [31:0] STATUS_RST = 32'h0;
`endif

    soc_system_led_pwm dut (
        .clk(clk),
        .reset(reset),
        .led_in(led_in),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .led_out(led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        led_in = '0;
        address = '0;
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = '0;
        tick(3);
        reset = 1'b0;
        led_in = 10'h3FF;
        tick(100);
        chk("run_on", 32'(led_out), 32'h3FF);
        reset = 1'b1;
        #1;
        chk("rst_async", 32'(led_out), 32'h0);
        rd(2'd0, 32'hFF, "rst_duty");
        rd(2'd1, 32'h0, "rst_mask");
        rd(2'd2, 32'h0, "rst_period");
        rd(2'd3, STATUS_RST, "rst_status");
        @(negedge clk);
        reset = 1'b0;
        tick(1);
        chk("rel_c1", 32'(led_out), 32'h0);
        tick(1);
        chk("rel_c2", 32'(led_out), 32'h3FF);
        address = 2'd0;
        writedata = '0;
        write_n = 1'b0;
        tick(1);
        write_n = 1'b1;
        rd(2'd0, 32'hFF, "no_cs_write");

        led_in = '0;
        tick(2);
        chk("full_zero", 32'(led_out), 32'h0);
        led_in = 10'h155;
        tick(1);
        chk("full_lat1", 32'(led_out), 32'h0);
        tick(1);
        chk("full_lat2", 32'(led_out), 32'h155);
        for (int i = 0; i < 300; i++) begin
            tick(1);
            chk("full_hold", 32'(led_out), 32'h155);
        end

        led_in = 10'h3FF;
        do_reset();
        wr(2'd0, 32'h40);
        rd(2'd0, 32'h40, "duty40_rb");
        tick(254);
        for (int m = 1; m <= 255; m++) begin
            tick(1);
            chk("duty40", 32'(led_out), m <= 64 ? 32'h3FF : 32'h0);
        end
        wr(2'd0, 32'h0);
        tick(254);
        for (int m = 1; m <= 255; m++) begin
            tick(1);
            chk("duty0", 32'(led_out), 32'h0);
        end

        do_reset();
        wr(2'd0, 32'h80);
        tick(508);
        wr(2'd0, 32'h10);
        on = 0;
        for (int m = 1; m <= 255; m++) begin
            tick(1);
            if (led_out == 10'h3FF) on++;
        end
        chk("wrap_frame128", 32'(on), 32'd128);
        on = 0;
        for (int m = 1; m <= 255; m++) begin
            tick(1);
            if (led_out == 10'h3FF) on++;
        end
        chk("wrap_frame16", 32'(on), 32'd16);

        do_reset();
`ifdef SOC_LED_PWM_BLINK_EN
        wr(2'd1, 32'h3);
        wr(2'd2, 32'h2);
        rd(2'd1, 32'h3, "mask_rb");
        rd(2'd2, 32'h2, "period_rb");
        tick(253);
        rd(2'd3, 32'h0001_0001, "status_f1");
        tick(255);
        chk("blink_on_end", 32'(led_out), 32'h3FF);
        rd(2'd3, 32'h0, "status_ph0");
        tick(1);
        chk("blink_off", 32'(led_out), 32'h3FC);
        tick(89);
        chk("blink_off_mid", 32'(led_out), 32'h3FC);
        wr(2'd2, 32'h2);
        rd(2'd3, 32'h1, "status_restart");
        tick(1);
        chk("blink_restart", 32'(led_out), 32'h3FF);
        tick(163);
        rd(2'd3, 32'h0001_0001, "status_rs_f1");
        tick(255);
        chk("blink_rs_end", 32'(led_out), 32'h3FF);
        tick(1);
        chk("blink_rs_off", 32'(led_out), 32'h3FC);
`else
        wr(2'd1, 32'h3FF);
        rd(2'd1, 32'h0, "off_mask");
        wr(2'd2, 32'h2);
        rd(2'd2, 32'h0, "off_period");
        rd(2'd3, 32'h0, "off_status");
        for (int i = 0; i < 1100; i++) begin
            tick(1);
            chk("off_noblink", 32'(led_out), 32'h3FF);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
